// File: rtl/invader_bombs_pkg.sv
// Shared constants and helpers for the invader bomb logic: playfield geometry,
// sprite/projectile sizes, fire timing and the bomb-vs-player hit test.
package invader_bombs_pkg;

    // Sprite and projectile geometry (scaled screen pixels)
    localparam logic [9:0]  SPRITE_WIDTH_SCALED  = 10'd32;
    localparam logic [9:0]  SPRITE_HEIGHT_SCALED = 10'd32;
    localparam logic [9:0]  PROJ_WIDTH_SCALED    = 10'd4;
    localparam logic [9:0]  PROJ_HEIGHT_SCALED   = 10'd16;
    localparam logic [9:0]  PLAYER_START_Y       = 10'd400;

    // Bomb system constants
    localparam int          NUM_BOMBS     = 3;
    localparam logic [5:0]  FIRE_INTERVAL = 6'd48;
    localparam logic [9:0]  BOMB_STEP     = 10'd4;
    localparam logic [9:0]  COL_PITCH     = 10'd48;
    localparam logic [10:0] GROUND_Y      = 11'd448;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    // Reduce a 3-bit random value onto the six invader columns
    function automatic logic [2:0] col_mod6(input logic [2:0] v);
        return (v >= 3'd6) ? v - 3'd6 : v;
    endfunction

    // Next column in the wrap-around scan 0..5
    function automatic logic [2:0] col_step(input logic [2:0] c);
        return (c == 3'd5) ? 3'd0 : c + 3'd1;
    endfunction

    // Bomb drops from the horizontal centre of the chosen column's sprite
    function automatic logic [9:0] spawn_x(input logic [9:0] inv_x, input logic [2:0] col);
        return inv_x + 10'(col) * COL_PITCH
               + (SPRITE_WIDTH_SCALED >> 1) - (PROJ_WIDTH_SCALED >> 1);
    endfunction

    // Bomb bottom edge at or below the ground line; widened so it cannot wrap
    function automatic logic ground_reached(input logic [9:0] y);
        return ({1'b0, y} + {1'b0, PROJ_HEIGHT_SCALED}) >= GROUND_Y;
    endfunction

    // Axis-aligned rectangle intersection of a bomb against the player sprite
    function automatic logic hits_player(input logic [9:0] bx, input logic [9:0] by,
                                         input logic [9:0] px);
        logic [10:0] bx_w, by_w, px_w, py_w;
        bx_w = {1'b0, bx};
        by_w = {1'b0, by};
        px_w = {1'b0, px};
        py_w = {1'b0, PLAYER_START_Y};
        return (bx_w < px_w + {1'b0, SPRITE_WIDTH_SCALED})
            && (px_w < bx_w + {1'b0, PROJ_WIDTH_SCALED})
            && (by_w < py_w + {1'b0, SPRITE_HEIGHT_SCALED})
            && (py_w < by_w + {1'b0, PROJ_HEIGHT_SCALED});
    endfunction

endpackage

// File: rtl/invader_bombs_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), stepped once per advance pulse.
import invader_bombs_pkg::*;

module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] value
);

    logic feedback;
    assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

    // Right-shifting register with feedback entering at the top bit
    always_ff @(posedge clk) begin
        if (rst)
            value <= LFSR_SEED;
        else if (advance)
            value <= {feedback, value[15:1]};
    end

endmodule

// File: rtl/invader_bombs.sv
// Invader bomb manager: fire timer, random column pick, three falling bomb
// slots with ground / shield / player collision and a player-hit pulse.
import invader_bombs_pkg::*;

module invader_bombs (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame,
    input  logic        enable,
    input  logic [9:0]  invaders_x,
    input  logic [9:0]  bottom_y,
    input  logic [5:0]  alive_cols,
    input  logic [9:0]  player_x,
    input  logic [2:0]  bomb_clear,
    output logic [2:0]  bomb_active,
    output logic [29:0] bomb_x,
    output logic [29:0] bomb_y,
    output logic        player_hit
);

    typedef enum logic [1:0] {WAIT, PICK, SPAWN} spawn_state_t;

    spawn_state_t state, state_next;
    logic [5:0]  frame_cnt, cnt_inc;
    logic [2:0]  col, scan_cnt;
    logic [15:0] lfsr_value;
    logic [NUM_BOMBS-1:0] slot_active, active_next;
    logic [29:0] x_next, y_next;
    logic [9:0]  moved_y;
    logic        advance, fire, col_alive, hit_any, spawn_done;
    logic        unused_lfsr;

    assign advance     = frame & enable;
    assign cnt_inc     = (frame_cnt == FIRE_INTERVAL) ? FIRE_INTERVAL : frame_cnt + 6'd1;
    // The timer expires on the frame that brings the count to the interval
    assign fire        = advance && (state == WAIT) && (cnt_inc == FIRE_INTERVAL)
                         && !(&slot_active) && (alive_cols != 6'd0);
    assign col_alive   = alive_cols[col];
    assign bomb_active = slot_active;
    assign unused_lfsr = ^lfsr_value[15:3];

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .value   (lfsr_value)
    );

    // Fire timer: counts frames, saturates, cleared when a shot is launched
    always_ff @(posedge clk) begin
        if (rst)
            frame_cnt <= 6'd0;
        else if (advance)
            frame_cnt <= fire ? 6'd0 : cnt_inc;
    end

    // Spawn FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= WAIT;
        else
            state <= state_next;
    end

    // Spawn FSM next state: scan at most six columns, then give up
    always_comb begin
        state_next = state;
        unique case (state)
            WAIT:  if (fire) state_next = PICK;
            PICK:  if (enable) begin
                       if (col_alive)              state_next = SPAWN;
                       else if (scan_cnt == 3'd5)  state_next = WAIT;
                   end
            SPAWN: if (enable) state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // Column scan pointer, seeded from the LFSR when a shot is launched
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= 3'd0;
            scan_cnt <= 3'd0;
        end else if (fire) begin
            col      <= col_mod6(lfsr_value[2:0]);
            scan_cnt <= 3'd0;
        end else if (state == PICK && enable && !col_alive) begin
            col      <= col_step(col);
            scan_cnt <= scan_cnt + 3'd1;
        end
    end

    // Per-slot motion and collisions (clear > ground > player), then spawn
    always_comb begin
        active_next = slot_active;
        x_next      = bomb_x;
        y_next      = bomb_y;
        moved_y     = 10'd0;
        hit_any     = 1'b0;
        spawn_done  = 1'b0;
        for (int n = 0; n < NUM_BOMBS; n++) begin
            moved_y = bomb_y[10*n +: 10] + BOMB_STEP;
            if (slot_active[n]) begin
                if (bomb_clear[n]) begin
                    active_next[n] = 1'b0;
                end else if (advance) begin
                    y_next[10*n +: 10] = moved_y;
                    if (ground_reached(moved_y)) begin
                        active_next[n] = 1'b0;
                    end else if (hits_player(bomb_x[10*n +: 10], moved_y, player_x)) begin
                        active_next[n] = 1'b0;
                        hit_any        = 1'b1;
                    end
                end
            end
        end
        if (state == SPAWN && enable) begin
            for (int n = 0; n < NUM_BOMBS; n++) begin
                if (!slot_active[n] && !spawn_done) begin
                    active_next[n]     = 1'b1;
                    x_next[10*n +: 10] = spawn_x(invaders_x, col);
                    y_next[10*n +: 10] = bottom_y;
                    spawn_done         = 1'b1;
                end
            end
        end
    end

    // Slot registers and the single-cycle hit pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_active <= '0;
            bomb_x      <= 30'd0;
            bomb_y      <= 30'd0;
            player_hit  <= 1'b0;
        end else begin
            slot_active <= active_next;
            bomb_x      <= x_next;
            bomb_y      <= y_next;
            player_hit  <= hit_any;
        end
    end

endmodule

// File: tb/tb_invader_bombs.sv
// Directed bench for invader_bombs: spawn, fall, ground, player hit, clear,
// full-slot blocking, dead formation and reset during column scan.
module tb_invader_bombs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame = 1'b0;
    logic        enable = 1'b1;
    logic [9:0]  invaders_x = 10'd100;
    logic [9:0]  bottom_y = 10'd200;
    logic [5:0]  alive_cols = 6'd0;
    logic [9:0]  player_x = 10'd500;
    logic [2:0]  bomb_clear = 3'd0;
    logic [2:0]  bomb_active;
    logic [29:0] bomb_x, bomb_y;
    logic        player_hit;

    int n_checks = 0;
    int n_fail   = 0;

    invader_bombs dut (
        .clk        (clk),
        .rst        (rst),
        .frame      (frame),
        .enable     (enable),
        .invaders_x (invaders_x),
        .bottom_y   (bottom_y),
        .alive_cols (alive_cols),
        .player_x   (player_x),
        .bomb_clear (bomb_clear),
        .bomb_active(bomb_active),
        .bomb_x     (bomb_x),
        .bomb_y     (bomb_y),
        .player_hit (player_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One-cycle frame pulse; returns at the falling edge after it was sampled
    task automatic frame_pulse();
        @(negedge clk) frame = 1'b1;
        @(negedge clk) frame = 1'b0;
    endtask

    // Pulse frames until slot idx goes active (bounded)
    task automatic wait_spawn(input int idx, input string tag);
        bit found = 1'b0;
        for (int f = 0; f < 60 && !found; f++) begin
            frame_pulse();
            repeat (8) @(negedge clk);
            if (bomb_active[idx]) found = 1'b1;
        end
        check(tag, found, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc, frames;
        bit  seen;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_active", bomb_active, 0);
        check("reset_x", bomb_x, 0);
        check("reset_y", bomb_y, 0);
        check("reset_hit", player_hit, 0);
        check("reset_lfsr", dut.lfsr_value, 16'hACE1);

        // First shot on the 48th frame, column 0 only
        alive_cols = 6'b000001;
        invaders_x = 10'd100;
        bottom_y   = 10'd200;
        player_x   = 10'd500;
        repeat (47) frame_pulse();
        check("no_spawn_before_48", bomb_active, 0);
        frame_pulse();
        cyc = 0;
        while (!bomb_active[0] && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("spawn_latency_le7", cyc <= 7, 1);
        alive_cols = 6'd0;
        check("spawn_active", bomb_active, 3'b001);
        check("spawn_x", bomb_x[9:0], 10'd114);
        check("spawn_y", bomb_y[9:0], 10'd200);

        // Fall by 4 per frame; frozen when disabled
        repeat (3) frame_pulse();
        check("fall_y212", bomb_y[9:0], 10'd212);
        enable = 1'b0;
        frame_pulse();
        check("disabled_hold_y", bomb_y[9:0], 10'd212);
        enable = 1'b1;

        // Ground: drops on the frame where y reaches 432 (55 frames from 212)
        frames = 0;
        seen   = 1'b0;
        while (bomb_active[0] && frames < 100) begin
            frame_pulse();
            frames++;
            if (player_hit) seen = 1'b1;
        end
        check("ground_frames", frames, 55);
        check("ground_no_hit", seen, 0);
        check("ground_y", bomb_y[9:0], 10'd432);

        // Player hit: bomb x=114 inside [100,132), hit when y reaches 388
        player_x   = 10'd100;
        alive_cols = 6'b000001;
        wait_spawn(0, "hit_spawn");
        alive_cols = 6'd0;
        check("hit_spawn_y", bomb_y[9:0], 10'd200);
        frames = 0;
        while (!player_hit && frames < 60) begin
            frame_pulse();
            frames++;
        end
        check("hit_frames", frames, 47);
        check("hit_pulse", player_hit, 1);
        check("hit_slot_idle", bomb_active[0], 0);
        @(negedge clk);
        check("hit_single_cycle", player_hit, 0);

        // Same fall, but cleared on the frame that would hit
        alive_cols = 6'b000001;
        wait_spawn(0, "clear_spawn");
        alive_cols = 6'd0;
        repeat (46) frame_pulse();
        check("clear_pre_y", bomb_y[9:0], 10'd384);
        check("clear_pre_active", bomb_active[0], 1);
        bomb_clear = 3'b001;
        frame_pulse();
        bomb_clear = 3'b000;
        check("clear_no_hit", player_hit, 0);
        check("clear_idle", bomb_active[0], 0);
        @(negedge clk);
        check("clear_no_hit_late", player_hit, 0);

        // All slots busy at expiry: no spawn, timer stays saturated
        player_x   = 10'd500;
        invaders_x = 10'd200;
        alive_cols = 6'b000100;
        force dut.slot_active = 3'b111;
        repeat (2) begin
            frame_pulse();
            repeat (8) @(negedge clk);
        end
        check("full_no_spawn_x", bomb_x, {10'd0, 10'd0, 10'd114});
        force dut.slot_active = 3'b101;
        @(negedge clk);
        release dut.slot_active;
        frame_pulse();
        repeat (8) @(negedge clk);
        check("refill_slot1", bomb_active[1], 1);
        check("refill_x", bomb_x[19:10], 10'd310);
        check("refill_y", bomb_y[19:10], 10'd200);

        // Dead formation: no bombs for 200 frames
        bomb_clear = 3'b111;
        alive_cols = 6'd0;
        @(negedge clk);
        bomb_clear = 3'b000;
        check("all_cleared", bomb_active, 0);
        seen = 1'b0;
        repeat (200) begin
            frame_pulse();
            if (bomb_active != 3'd0) seen = 1'b1;
        end
        check("dead_no_bombs", seen, 0);

        // Reset while scanning columns aborts the shot
        alive_cols = 6'b100000;
        frame_pulse();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("pick_rst_active", bomb_active, 0);
        check("pick_rst_x", bomb_x, 0);
        check("pick_rst_y", bomb_y, 0);
        check("pick_rst_hit", player_hit, 0);
        check("pick_rst_lfsr", dut.lfsr_value, 16'hACE1);
        repeat (10) @(negedge clk);
        check("pick_rst_no_load", bomb_active, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
